// File: rtl/seq_alu.sv
// Clocked WIDTH-bit ALU with valid/ready handshake, registered flags
// and a shift-add multiplier returning the full double-width product.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             mode,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             c_out,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]   a_q, b_q;
  logic               c_in_q, mode_q;
  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;

  logic               accept, is_mul;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic [WIDTH:0]     ext;
  logic [WIDTH:0]     mul_sum;

  assign accept    = in_valid & in_ready;
  assign is_mul    = mode & (op == 3'b100);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = is_mul ? MUL : EXEC;
      EXEC: state_nx = DONE;
      MUL:  if (cnt == CNT_LAST) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    ext     = '0;
    if (!mode_q) begin
      unique case (op_q)
        3'b000: alu_res = a_q & b_q;
        3'b001: alu_res = a_q | b_q;
        3'b010: alu_res = ~(a_q & b_q);
        3'b011: alu_res = ~(a_q | b_q);
        3'b100: alu_res = a_q ^ b_q;
        3'b101: alu_res = ~(a_q ^ b_q);
        3'b110: alu_res = ~a_q;
        3'b111: alu_res = ~b_q;
      endcase
    end else begin
      unique case (op_q)
        3'b000: begin
          alu_res = ~a_q + ONE;
          alu_c   = (a_q == '0);
        end
        3'b001: begin
          alu_res = ~b_q + ONE;
          alu_c   = (b_q == '0);
        end
        3'b010: begin
          ext = {1'b0, a_q} + {1'b0, b_q}
              + {{WIDTH{1'b0}}, c_in_q};
          {alu_c, alu_res} = ext;
        end
        3'b011: begin
          alu_c   = (a_q >= b_q);
          alu_res = alu_c ? a_q - b_q : b_q - a_q;
        end
        3'b100: alu_res = '0;
        3'b101: begin
          alu_c   = (b_q >= a_q);
          alu_res = alu_c ? b_q - a_q : a_q - b_q;
        end
        3'b110: begin
          ext = {1'b0, a_q} + {1'b0, ONE};
          {alu_c, alu_res} = ext;
        end
        3'b111: begin
          alu_res = a_q - ONE;
          alu_c   = (a_q != '0);
        end
      endcase
    end
  end

  // Low half starts as the multiplier and shifts out as the product grows.
  assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]}
                 + {1'b0, (prod[0] ? a_q : {WIDTH{1'b0}})};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      c_in_q    <= 1'b0;
      mode_q    <= 1'b0;
      op_q      <= '0;
      prod      <= '0;
      cnt       <= '0;
      result    <= '0;
      result_hi <= '0;
      c_out     <= 1'b0;
      zero      <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_q    <= a;
            b_q    <= b;
            c_in_q <= c_in;
            mode_q <= mode;
            op_q   <= op;
            prod   <= {{WIDTH{1'b0}}, b};
            cnt    <= '0;
          end
        end
        EXEC: begin
          result    <= alu_res;
          result_hi <= '0;
          c_out     <= alu_c;
          zero      <= (alu_res == '0);
        end
        MUL: begin
          if (cnt == CNT_LAST) begin
            result    <= prod[WIDTH-1:0];
            result_hi <= prod[2*WIDTH-1:WIDTH];
            c_out     <= |prod[2*WIDTH-1:WIDTH];
            zero      <= (prod == '0);
          end else begin
            prod <= {mul_sum, prod[WIDTH-1:1]};
            cnt  <= cnt + CW'(1);
          end
        end
        DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed and randomized checks of seq_alu against an arithmetic
// reference model; includes a WIDTH=4 instance for the small multiply.
module tb_seq_alu;

  localparam int W  = 8;
  localparam int W4 = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         c_in = 1'b0, mode = 1'b0;
  logic [2:0]   op = '0;
  logic         out_valid, out_ready = 1'b0;
  logic [W-1:0] result, result_hi;
  logic         c_out, zero;

  logic          in_valid4 = 1'b0, in_ready4;
  logic [W4-1:0] a4 = '0, b4 = '0;
  logic          c_in4 = 1'b0, mode4 = 1'b0;
  logic [2:0]    op4 = '0;
  logic          out_valid4, out_ready4 = 1'b0;
  logic [W4-1:0] result4, result_hi4;
  logic          c_out4, zero4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .mode(mode), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi),
    .c_out(c_out), .zero(zero)
  );

  seq_alu #(.WIDTH(W4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .c_in(c_in4), .mode(mode4), .op(op4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .result(result4), .result_hi(result_hi4),
    .c_out(c_out4), .zero(zero4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns {c_out, result_hi, result}.
  function automatic logic [2*W:0] ref_op(input int ia, input int ib,
      input bit icin, input bit imode, input int iop);
    int M;
    int r, h, s;
    bit c;
    logic [W-1:0] la, lb, lr;
    M = 1 << W;
    r = 0; h = 0; c = 0; s = 0;
    la = W'(ia);
    lb = W'(ib);
    lr = '0;
    if (!imode) begin
      case (iop)
        0: lr = la & lb;
        1: lr = la | lb;
        2: lr = ~(la & lb);
        3: lr = ~(la | lb);
        4: lr = la ^ lb;
        5: lr = ~(la ^ lb);
        6: lr = ~la;
        default: lr = ~lb;
      endcase
      r = int'(lr);
    end else begin
      case (iop)
        0: begin r = (M - ia) % M; c = (ia == 0); end
        1: begin r = (M - ib) % M; c = (ib == 0); end
        2: begin s = ia + ib + int'(icin); r = s % M; c = s >= M; end
        3: begin r = ia >= ib ? ia - ib : ib - ia; c = ia >= ib; end
        4: begin s = ia * ib; r = s % M; h = s / M; c = h != 0; end
        5: begin r = ib >= ia ? ib - ia : ia - ib; c = ib >= ia; end
        6: begin s = ia + 1; r = s % M; c = s >= M; end
        default: begin r = (ia + M - 1) % M; c = ia != 0; end
      endcase
    end
    return {c, W'(h), W'(r)};
  endfunction

  task automatic issue(input int ia, input int ib, input bit icin,
                       input bit imode, input int iop);
    int lat;
    logic [2*W:0] e;
    string t;
    e = ref_op(ia, ib, icin, imode, iop);
    t = $sformatf("m%0d op%0d a=%0d b=%0d", imode, iop, ia, ib);
    a = W'(ia); b = W'(ib); c_in = icin; mode = imode;
    op = 3'(iop);
    in_valid = 1'b1;
    chk({t, " in_ready"}, 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({t, " latency"}, lat, (imode && iop == 4) ? W + 1 : 1);
    chk({t, " result"}, 32'(result), 32'(e[W-1:0]));
    chk({t, " result_hi"}, 32'(result_hi), 32'(e[2*W-1:W]));
    chk({t, " c_out"}, 32'(c_out), 32'(e[2*W]));
    chk({t, " zero"}, 32'(zero), 32'(e[2*W-1:0] == '0));
    chk({t, " busy"}, 32'(in_ready), 0);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("consume out_valid", 32'(out_valid), 0);
    chk("consume in_ready", 32'(in_ready), 1);
  endtask

  initial begin
    int lat;
    bit seen;

    rst = 1'b1;
    tick();
    tick();
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst result", 32'(result), 0);
    chk("rst zero", 32'(zero), 0);
    rst = 1'b0;

    a4 = 4'd15; b4 = 4'd15; mode4 = 1'b1; op4 = 3'b100;
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 40) begin
      tick();
      lat++;
    end
    chk("w4 mul latency", lat, 5);
    chk("w4 mul hi", 32'(result_hi4), 14);
    chk("w4 mul lo", 32'(result4), 1);
    chk("w4 mul c_out", 32'(c_out4), 1);
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    chk("w4 consume", 32'(out_valid4), 0);

    issue(200, 100, 1, 1, 2);
    chk("add const result", 32'(result), 45);
    chk("add const c_out", 32'(c_out), 1);
    consume();
    issue(5, 9, 0, 1, 3);
    chk("sub const result", 32'(result), 4);
    chk("sub const c_out", 32'(c_out), 0);
    consume();
    issue(255, 255, 0, 1, 4);
    chk("mul const", 32'({result_hi, result}), 32'h0000_FE01);
    consume();
    issue(0, 77, 0, 1, 4);
    chk("mul zero const", 32'(zero), 1);
    consume();
    issue(0, 3, 1, 1, 7);
    chk("dec0 const", 32'(result), 32'hFF);
    consume();
    issue(0, 3, 1, 1, 0);
    chk("neg0 const", 32'({c_out, zero, result}), 32'h200 | 32'h100);
    consume();
    issue(255, 0, 0, 1, 6);
    chk("inc255 const", 32'({c_out, result}), 32'h100);
    consume();

    issue(10, 20, 0, 1, 2);
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      in_valid = 1'($urandom);
      tick();
      chk("bp result", 32'(result), 30);
      chk("bp in_ready", 32'(in_ready), 0);
      chk("bp out_valid", 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    consume();
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("bp single result", 32'(seen), 0);

    issue(1, 2, 0, 1, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst done out_valid", 32'(out_valid), 0);
    chk("rst done in_ready", 32'(in_ready), 1);
    chk("rst done outs",
        32'({result, result_hi, c_out, zero}), 0);

    a = 8'd13; b = 8'd11; mode = 1'b1; op = 3'b100;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("mul abort no out", 32'(seen), 0);
    chk("mul abort ready", 32'(in_ready), 1);
    issue(7, 8, 1, 1, 2);
    chk("add after abort", 32'(result), 16);
    consume();

    for (int i = 0; i < 40; i++) begin
      issue(int'($urandom_range(255)), int'($urandom_range(255)),
            1'($urandom), 1'($urandom), int'($urandom_range(7)));
      consume();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
